// File: rtl/if_prefetch_queue_if.sv
// Instruction-memory bus between the fetch front end (master) and the instruction memory (slave).
// A request is accepted when req & gnt; responses come back in request order on rvalid/rdata.
interface if_prefetch_queue_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction fetch front end with an in-order prefetch queue feeding the IF/ID register.
// Credits bound queue occupancy plus in-flight requests to DEPTH, so a response always has a
// free slot. On a redirect, responses still in flight are counted off and discarded.
module if_prefetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    if_prefetch_queue_if.master        imem,
    output logic [31:0]                if_id_ir,
    output logic [31:0]                if_id_npc,
    output logic                       if_id_valid
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW:0] DepthC = (CntW + 1)'(DEPTH);

    logic [31:0]     pc_q, pc_d;
    logic [31:0]     resp_pc_q, resp_pc_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic [31:0]     ir_q, ir_d;
    logic [31:0]     npc_q, npc_d;
    logic            valid_q, valid_d;

    logic [31:0]     q_ir  [DEPTH];
    logic [31:0]     q_npc [DEPTH];

    logic [CntW:0]   in_use;
    logic            credit;
    logic            handshake;
    logic            rsp_ok;
    logic            push;
    logic            pop;

    assign in_use    = {1'b0, count_q} + {1'b0, outstanding_q};
    assign credit    = in_use < DepthC;
    assign imem.req  = !reset && !redirect && credit;
    assign imem.addr = pc_q;
    assign handshake = imem.req && imem.gnt;
    // A response with nothing outstanding is a protocol error and is ignored entirely.
    assign rsp_ok    = imem.rvalid && (outstanding_q != '0);
    assign push      = rsp_ok && !redirect && (drop_q == '0);
    assign pop       = !redirect && !stall && (count_q != '0);

    assign if_id_ir    = ir_q;
    assign if_id_npc   = npc_q;
    assign if_id_valid = valid_q;

    // Next-state: fetch pointer, credits, drop counting, queue bookkeeping and IF/ID load.
    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        ir_d          = ir_q;
        npc_d         = npc_q;
        valid_d       = valid_q;

        if (redirect) begin
            pc_d          = redirect_pc;
            resp_pc_d     = redirect_pc;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            count_d       = '0;
            // The word arriving this cycle is already stale, so it is not counted again.
            outstanding_d = outstanding_q - CntW'(rsp_ok);
            drop_d        = outstanding_d;
            ir_d          = 32'h0;
            valid_d       = 1'b0;
        end else begin
            if (handshake) begin
                pc_d = pc_q + 32'd4;
            end
            outstanding_d = outstanding_q + CntW'(handshake) - CntW'(rsp_ok);
            if (rsp_ok && (drop_q != '0)) begin
                drop_d = drop_q - CntW'(1);
            end
            if (push) begin
                wr_ptr_d  = wr_ptr_q + PtrW'(1);
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
            if (!stall) begin
                if (count_q != '0) begin
                    ir_d    = q_ir[rd_ptr_q];
                    npc_d   = q_npc[rd_ptr_q];
                    valid_d = 1'b1;
                end else begin
                    ir_d    = 32'h0;
                    valid_d = 1'b0;
                end
            end
        end
    end

    // Control state and IF/ID register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            ir_q          <= 32'h0;
            npc_q         <= 32'h0;
            valid_q       <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            ir_q          <= ir_d;
            npc_q         <= npc_d;
            valid_q       <= valid_d;
        end
    end

    // Queue storage; validity is tracked by the pointers, so the data needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            q_ir[wr_ptr_q]  <= imem.rdata;
            q_npc[wr_ptr_q] <= resp_pc_q + 32'd4;
        end
    end

endmodule
